// File: rtl/casl_pkg.sv
// Shared types, defaults and the chain-gate evaluation helper for the CAS-Lock cascade.
package casl_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ARMED = 2'd2
  } casl_state_e;

  localparam logic [31:0] CASL_CHAIN_CFG_DEF = 32'hFD84FC80;
  localparam int unsigned CASL_MAXW          = 64;

  // Folds w chain bits into the incoming partial result; cfg bit 1 = OR stage, 0 = AND stage.
  function automatic logic casl_stage(input logic [CASL_MAXW-1:0] cfg,
                                      input logic [CASL_MAXW-1:0] x,
                                      input logic                 c_in,
                                      input int unsigned          w);
    logic c;
    c = c_in;
    for (int unsigned i = 0; i < CASL_MAXW; i++) begin
      if (i < w) c = cfg[i] ? (x[i] | c) : (x[i] & c);
    end
    return c;
  endfunction

endpackage

// File: rtl/casl_chain_seg.sv
// One registered SEG-bit slice of both key-gate chains, carrying valid and the host bit.
module casl_chain_seg
  import casl_pkg::*;
#(
  parameter int unsigned    SEG  = 8,
  parameter logic [SEG-1:0] CFG  = '0,
  parameter logic [SEG-1:0] INV1 = '0,
  parameter logic [SEG-1:0] INV2 = '0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush_i,
  input  logic           valid_i,
  input  logic           prot_i,
  input  logic [SEG-1:0] data_i,
  input  logic [SEG-1:0] key1_i,
  input  logic [SEG-1:0] key2_i,
  input  logic           c1_i,
  input  logic           c2_i,
  output logic           valid_o,
  output logic           prot_o,
  output logic           c1_o,
  output logic           c2_o
);

  logic [SEG-1:0] x1, x2;
  logic           valid_d, valid_q;
  logic           prot_d, prot_q;
  logic           c1_d, c1_q;
  logic           c2_d, c2_q;

  always_comb begin
    x1      = data_i ^ key1_i ^ INV1;
    x2      = data_i ^ key2_i ^ INV2;
    c1_d    = casl_stage(CASL_MAXW'(CFG), CASL_MAXW'(x1), c1_i, SEG);
    c2_d    = casl_stage(CASL_MAXW'(CFG), CASL_MAXW'(x2), c2_i, SEG);
    prot_d  = prot_i;
    valid_d = valid_i & ~flush_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      prot_q  <= 1'b0;
      c1_q    <= 1'b0;
      c2_q    <= 1'b0;
    end else begin
      valid_q <= valid_d;
      prot_q  <= prot_d;
      c1_q    <= c1_d;
      c2_q    <= c2_d;
    end
  end

  assign valid_o = valid_q;
  assign prot_o  = prot_q;
  assign c1_o    = c1_q;
  assign c2_o    = c2_q;

endmodule

// File: rtl/casl_seq_lock.sv
// CAS-Lock cascade with serial key loader, N/SEG-stage chain pipeline and output flip register.
module casl_seq_lock
  import casl_pkg::*;
#(
  parameter int unsigned  N         = 32,
  parameter int unsigned  SEG       = 8,
  parameter logic [N-1:0] CHAIN_CFG = N'(CASL_CHAIN_CFG_DEF),
  parameter logic [N-1:0] INV1      = '0,
  parameter logic [N-1:0] INV2      = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_bit_i,
  input  logic         key_valid_i,
  output logic         key_ready_o,
  input  logic         key_clear_i,
  output logic         armed_o,
  input  logic         in_valid_i,
  input  logic [N-1:0] in_data_i,
  input  logic         in_prot_i,
  output logic         out_valid_o,
  output logic         out_prot_o
);

  localparam int unsigned NS   = N / SEG;
  localparam int unsigned IDXW = $clog2(2 * N);
  localparam int unsigned CNTW = IDXW + 1;
  // Bit 0 forced to OR with a zero seed, so the first chain bit passes straight through.
  localparam logic [N-1:0] CFG_EFF = CHAIN_CFG | N'(1);

  casl_state_e     state_d, state_q;
  logic [CNTW-1:0] cnt_d, cnt_q;
  logic [2*N-1:0]  key_d, key_q;
  logic            beat;
  logic            out_valid_d, out_valid_q;
  logic            out_prot_d, out_prot_q;

  logic [NS:0] v_p, p_p, c1_p, c2_p;

  assign key_ready_o = (state_q != ST_ARMED);
  assign armed_o     = (state_q == ST_ARMED);
  assign beat        = key_valid_i & key_ready_o;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    if (key_clear_i) begin
      state_d = ST_EMPTY;
      cnt_d   = '0;
      key_d   = '0;
    end else if (beat) begin
      key_d[cnt_q[IDXW-1:0]] = key_bit_i;
      cnt_d   = cnt_q + CNTW'(1);
      state_d = (cnt_q == CNTW'(2 * N - 1)) ? ST_ARMED : ST_LOAD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      cnt_q   <= '0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
    end
  end

  assign v_p[0]  = in_valid_i & armed_o & ~key_clear_i;
  assign p_p[0]  = in_prot_i;
  assign c1_p[0] = 1'b0;
  assign c2_p[0] = 1'b0;

  for (genvar s = 0; s < NS; s++) begin : g_stage
    localparam int unsigned DW = N - s * SEG;
    logic [DW-1:0] data_w;

    if (s == 0) begin : g_head
      assign data_w = in_data_i;
    end else begin : g_body
      // Each stage keeps only the input bits not yet consumed by earlier segments.
      logic [DW-1:0] data_d, data_q;
      always_comb data_d = g_stage[s-1].data_w[N-(s-1)*SEG-1:SEG];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) data_q <= '0;
        else        data_q <= data_d;
      end
      assign data_w = data_q;
    end

    casl_chain_seg #(
      .SEG  (SEG),
      .CFG  (CFG_EFF[s*SEG +: SEG]),
      .INV1 (INV1[s*SEG +: SEG]),
      .INV2 (INV2[s*SEG +: SEG])
    ) u_seg (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (key_clear_i),
      .valid_i (v_p[s]),
      .prot_i  (p_p[s]),
      .data_i  (data_w[SEG-1:0]),
      .key1_i  (key_q[s*SEG +: SEG]),
      .key2_i  (key_q[N+s*SEG +: SEG]),
      .c1_i    (c1_p[s]),
      .c2_i    (c2_p[s]),
      .valid_o (v_p[s+1]),
      .prot_o  (p_p[s+1]),
      .c1_o    (c1_p[s+1]),
      .c2_o    (c2_p[s+1])
    );
  end

  always_comb begin
    out_valid_d = v_p[NS] & ~key_clear_i;
    out_prot_d  = out_prot_q;
    if (out_valid_d) out_prot_d = p_p[NS] ^ (c1_p[NS] & ~c2_p[NS]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_prot_q  <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_prot_q  <= out_prot_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_prot_o  = out_prot_q;

endmodule

// File: tb/tb_casl_seq_lock.sv
// Scoreboard bench for casl_seq_lock: driver queues expected flips, monitor checks each output.
module tb_casl_seq_lock;

  localparam bit [31:0] M_CFG  = 32'hFD84FC80;
  localparam bit [31:0] M_INV1 = 32'h0;
  localparam bit [31:0] M_INV2 = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_bit_i = 1'b0;
  logic        key_valid_i = 1'b0;
  logic        key_ready_o;
  logic        key_clear_i = 1'b0;
  logic        armed_o;
  logic        in_valid_i = 1'b0;
  logic [31:0] in_data_i = '0;
  logic        in_prot_i = 1'b0;
  logic        out_valid_o;
  logic        out_prot_o;

  typedef struct {
    int due;
    bit prot;
  } exp_t;

  exp_t      sb_q[$];
  int        n_tests = 0;
  int        n_fail  = 0;
  int        n_out   = 0;
  int        cyc     = 0;
  bit        m_armed = 0;
  bit [63:0] m_key   = '0;
  bit        last_prot = 0;

  casl_seq_lock #(.N(32), .SEG(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_bit_i   (key_bit_i),
    .key_valid_i (key_valid_i),
    .key_ready_o (key_ready_o),
    .key_clear_i (key_clear_i),
    .armed_o     (armed_o),
    .in_valid_i  (in_valid_i),
    .in_data_i   (in_data_i),
    .in_prot_i   (in_prot_i),
    .out_valid_o (out_valid_o),
    .out_prot_o  (out_prot_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  // Reference: straight evaluation of both chains bit by bit from the gate equations.
  function automatic bit model_casop(input bit [31:0] d, input bit [63:0] k);
    bit [31:0] x1, x2;
    bit c1, c2;
    x1 = d ^ k[31:0] ^ M_INV1;
    x2 = d ^ k[63:32] ^ M_INV2;
    c1 = x1[0];
    c2 = x2[0];
    for (int i = 1; i < 32; i++) begin
      c1 = M_CFG[i] ? (x1[i] | c1) : (x1[i] & c1);
      c2 = M_CFG[i] ? (x2[i] | c2) : (x2[i] & c2);
    end
    return c1 & ~c2;
  endfunction

  task automatic check(input string name, input logic act, input logic req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0b, required %0b (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid_o) begin
        n_tests++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_out: out_valid_o=1 out_prot_o=%0b at cycle %0d, required no output",
                   out_prot_o, cyc);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          n_out++;
          if (out_prot_o !== e.prot || cyc != e.due) begin
            n_fail++;
            $display("FAIL out_item: got prot=%0b at cycle %0d, required prot=%0b at cycle %0d",
                     out_prot_o, cyc, e.prot, e.due);
          end
        end
        last_prot = out_prot_o;
      end else if (out_prot_o !== last_prot) begin
        n_tests++;
        n_fail++;
        $display("FAIL prot_hold: got %0b, required held %0b (cycle %0d)", out_prot_o, last_prot, cyc);
      end
    end else begin
      last_prot = 0;
    end
  end

  task automatic load_key(input bit [63:0] k, input int gap);
    for (int i = 0; i < 64; i++) begin
      key_bit_i   = k[i];
      key_valid_i = 1'b1;
      @(negedge clk);
      key_valid_i = 1'b0;
      if (i == 62) check("armed_before_last_beat", armed_o, 1'b0);
      if (i == 63) begin
        check("armed_after_last_beat", armed_o, 1'b1);
        check("ready_when_armed", key_ready_o, 1'b0);
      end
      repeat (gap) @(negedge clk);
    end
    m_key   = k;
    m_armed = 1;
  endtask

  task automatic issue(input bit [31:0] d, input bit p);
    in_valid_i = 1'b1;
    in_data_i  = d;
    in_prot_i  = p;
    if (m_armed) sb_q.push_back('{due: cyc + 5, prot: p ^ model_casop(d, m_key)});
    @(negedge clk);
    in_valid_i = 1'b0;
  endtask

  task automatic do_clear(input bit with_beat);
    key_clear_i = 1'b1;
    key_valid_i = with_beat;
    key_bit_i   = 1'b1;
    in_valid_i  = 1'b0;
    while (sb_q.size() != 0 && sb_q[$].due >= cyc + 1) void'(sb_q.pop_back());
    m_armed = 0;
    @(negedge clk);
    key_clear_i = 1'b0;
    key_valid_i = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && sb_q.size() != 0; i++) @(negedge clk);
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d items outstanding, required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    bit [63:0] rk;
    int        outs_before;

    repeat (3) @(negedge clk);
    check("rst_armed", armed_o, 1'b0);
    check("rst_ready", key_ready_o, 1'b1);
    check("rst_out_valid", out_valid_o, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_armed", armed_o, 1'b0);
    check("post_rst_ready", key_ready_o, 1'b1);
    check("post_rst_out_valid", out_valid_o, 1'b0);
    check("post_rst_out_prot", out_prot_o, 1'b0);

    load_key({32'hFFFF_FFFF, 32'h0000_0000}, 1);

    key_bit_i   = 1'b1;
    key_valid_i = 1'b1;
    @(negedge clk);
    key_valid_i = 1'b0;
    check("extra_beat_armed", armed_o, 1'b1);
    check("extra_beat_ready", key_ready_o, 1'b0);

    issue(32'h0000_0000, 1'b1);
    repeat (6) @(negedge clk);
    issue(32'hFFFF_FFFF, 1'b0);
    repeat (6) @(negedge clk);
    drain();

    outs_before = n_out;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) issue(32'h0000_0000, 1'b1);
      else            issue(32'hFFFF_FFFF, 1'b0);
    end
    drain();
    n_tests++;
    if (n_out - outs_before != 6) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d outputs, required 6", n_out - outs_before);
    end

    issue($urandom, 1'b0);
    issue($urandom, 1'b1);
    do_clear(1'b1);
    check("clear_armed", armed_o, 1'b0);
    check("clear_ready", key_ready_o, 1'b1);
    repeat (8) @(negedge clk);

    for (int i = 0; i < 3; i++) issue($urandom, 1'(i));
    repeat (8) @(negedge clk);

    rk = {$urandom, $urandom};
    load_key(rk, 0);
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) != 0) issue($urandom, 1'($urandom_range(0, 1)));
      else @(negedge clk);
    end
    drain();

    do_clear(1'b0);
    rk = {$urandom, $urandom};
    load_key(rk, 1);
    for (int i = 0; i < 30; i++) issue($urandom, 1'($urandom_range(0, 1)));
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
